elevator_scheduler: RTL and testbench
=====================================

// Module: elevator_scheduler
// PURPOSE
//  Single-cab collective (SCAN) scheduler. Takes latched floor requests from the button
//  latch block (cab, hall-up, hall-down) and drives the motor and door timing. Tracks the
//  current floor and pulses one-hot clear strobes back to the latch when a floor is served.
// PARAMETERS
//  FLOORS       8   number of floors / request vector width (>=2)
//  FLOOR_TICKS  16  clk cycles to travel one floor (>=2)
//  DOOR_TICKS   32  clk cycles door stays open (>=2)
// PORTS
//  clk              in   1       system clock, all logic on posedge
//  reset            in   1       reset, synchronous, active-low
//  req_in           in   FLOORS  latched cab requests, bit f = floor f
//  req_up           in   FLOORS  latched hall-up requests
//  req_down         in   FLOORS  latched hall-down requests
//  cur_floor        out  FW      current floor, FW=$clog2(FLOORS)
//  motor_up         out  1       cab moving up
//  motor_down       out  1       cab moving down
//  door_open        out  1       door open
//  dir_up           out  1       committed/last travel direction (1=up)
//  clr_in           out  FLOORS  1-cycle one-hot clear of req_in
//  clr_up           out  FLOORS  1-cycle one-hot clear of req_up
//  clr_down         out  FLOORS  1-cycle one-hot clear of req_down
//  door_hold        in   1       [ELEVATOR_DOOR_HOLD_EN only] hold/obstruction button
// BEHAVIOUR
//  Reset (reset=0 at posedge): state IDLE, cur_floor=0, dir_up=1, all outputs 0, timer 0.
//   Reset mid-travel or with door open takes effect on that edge; no clear pulses issued.
//  States: IDLE, MOVE_UP, MOVE_DOWN, DOOR. Registered outputs; motor_up=(MOVE_UP),
//   motor_down=(MOVE_DOWN), door_open=(DOOR).
//  above = |req bits at floors > cur_floor; below = floors < cur_floor; here = any bit at cur.
//  IDLE: here -> DOOR; else dir_up&above -> MOVE_UP; else below -> MOVE_DOWN, dir_up<=0;
//   else above -> MOVE_UP, dir_up<=1; else stay. Decision latency: 1 cycle after request.
//  MOVE_x: timer loads FLOOR_TICKS-1 on entry, decrements; at 0 cur_floor +/-1 and stop test:
//   up: stop if req_in|req_up at new floor, or req_down there and nothing above it, or top floor.
//   down: mirror (req_in|req_down, or req_up with nothing below, or floor 0).
//   stop -> DOOR; else reload timer, continue. Never passes floor 0 or FLOORS-1.
//  DOOR: timer loads DOOR_TICKS-1 on entry. Clear pulse on entry cycle for served bits at
//   cur_floor: clr_in always; clr_up if dir_up or no below; clr_down if !dir_up or no above.
//  DOOR: new request for cur_floor matching served direction -> clear pulse next cycle and
//   timer reload. At timer 0 -> IDLE (re-evaluates; door_open low >=1 cycle between stops).
//  Simultaneous request+clear on same bit: latch block gives set priority; scheduler re-serves.
//  Clear vectors are 0 outside DOOR entry/reload cycles; at most one bit set per vector.
// CONFIGURATION
//  `ELEVATOR_DOOR_HOLD_EN defined: door_hold port exists; while door_hold=1 in DOOR the door
//   timer reloads to DOOR_TICKS-1 every cycle; door closes DOOR_TICKS cycles after release.
//  Undefined: no door_hold port; door time fixed as above.
// STRUCTURE
//  elevator_pkg: state enum (IDLE/MOVE_UP/MOVE_DOWN/DOOR), FW function ($clog2), dir consts.
//  Sub-module elevator_tick_timer: loadable down-counter (load, value, zero flag),
//   instantiated once, shared by travel and door phases.
//  Above/below reduction via masked OR loops in the scheduler.
// TESTING
//  1 reset, req_in=8'h08 -> MOVE_UP, floor 3 after 3*FLOOR_TICKS, DOOR, clr_in=8'h08 one cycle.
//  2 at floor 3 idle, req_down[5]=1 and req_up[1]=1 -> serves 5 first (dir_up held), then 1.
//  3 moving up past 2 toward 6, req_down[4] arrives -> no stop at 4; stop at 6, then 4 on return.
//  4 door open at floor 2, req_in[2] pulses -> clr_in=8'h04, door stays DOOR_TICKS more.
//  5 reset=0 mid MOVE_DOWN at floor 5 -> next cycle floor 0, IDLE, motors 0, no clears.
//  6 [HOLD_EN] door_hold=1 for 100 cycles -> door_open stays 1 until DOOR_TICKS after release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator scheduler slice.
// Optional build macro: ELEVATOR_DOOR_HOLD_EN (door hold button).
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bit width needed to index n items; never narrower than one bit.
    function automatic int fw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elevator_tick_timer.sv
// Loadable down-counter shared by the travel and door phases; holds at zero.
// Build macro ELEVATOR_DOOR_HOLD_EN does not affect this block.
module elevator_tick_timer
    import elevator_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// Single-cab SCAN scheduler: motor/door sequencing and request clear strobes.
// Define ELEVATOR_DOOR_HOLD_EN to add the door_hold input that keeps the door open.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOORS      = 8,
    parameter int FLOOR_TICKS = 16,
    parameter int DOOR_TICKS  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [FLOORS-1:0]       req_in,
    input  logic [FLOORS-1:0]       req_up,
    input  logic [FLOORS-1:0]       req_down,
`ifdef ELEVATOR_DOOR_HOLD_EN
    input  logic                    door_hold,
`endif
    output logic [fw(FLOORS)-1:0]   cur_floor,
    output logic                    motor_up,
    output logic                    motor_down,
    output logic                    door_open,
    output logic                    dir_up,
    output logic [FLOORS-1:0]       clr_in,
    output logic [FLOORS-1:0]       clr_up,
    output logic [FLOORS-1:0]       clr_down
);

    localparam int FW   = fw(FLOORS);
    localparam int TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int TW   = fw(TMAX);
    localparam logic [TW-1:0]     TRAVEL_LOAD = TW'(FLOOR_TICKS - 1);
    localparam logic [TW-1:0]     DOOR_LOAD   = TW'(DOOR_TICKS - 1);
    localparam logic [FLOORS-1:0] ONE         = FLOORS'(1);

    function automatic logic any_above(input logic [FLOORS-1:0] v, input int f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > f) r = r | v[i];
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [FLOORS-1:0] v, input int f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i < f) r = r | v[i];
        end
        return r;
    endfunction

    // Bits at floor f that a stop in direction up serves: {in, up, down}.
    function automatic logic [2:0] served_at(input logic [FLOORS-1:0] ri,
                                             input logic [FLOORS-1:0] ru,
                                             input logic [FLOORS-1:0] rd,
                                             input int f, input logic up);
        logic [FLOORS-1:0] all;
        all = ri | ru | rd;
        return {ri[f],
                ru[f] & (up | !any_below(all, f)),
                rd[f] & (!up | !any_above(all, f))};
    endfunction

    state_e            state_q, state_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic              dir_q, dir_d;
    logic              motor_up_q, motor_down_q, door_open_q;
    logic [FLOORS-1:0] clr_in_q, clr_up_q, clr_down_q;
    logic [FLOORS-1:0] clr_in_d, clr_up_d, clr_down_d;
    logic [FLOORS-1:0] all_req;
    logic [2:0]        srv;
    logic              above, below, stop, hold;
    logic              tmr_load, tmr_zero;
    logic [TW-1:0]     tmr_value;
    int                cf, nf;

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    elevator_tick_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        srv       = '0;
        stop      = 1'b0;
        cf        = int'(floor_q);
        nf        = cf;
        all_req   = req_in | req_up | req_down;
        above     = any_above(all_req, cf);
        below     = any_below(all_req, cf);

        case (state_q)
            IDLE: begin
                // Only open for bits this direction actually clears, so the door cannot cycle forever.
                srv = served_at(req_in, req_up, req_down, cf, dir_q);
                if (|srv) begin
                    state_d = DOOR;  tmr_load = 1'b1; tmr_value = DOOR_LOAD;
                end else if (dir_q && above) begin
                    state_d = MOVE_UP;   tmr_load = 1'b1; tmr_value = TRAVEL_LOAD;
                end else if (below) begin
                    state_d = MOVE_DOWN; tmr_load = 1'b1; tmr_value = TRAVEL_LOAD;
                    dir_d   = DIR_DOWN;
                end else if (above) begin
                    state_d = MOVE_UP;   tmr_load = 1'b1; tmr_value = TRAVEL_LOAD;
                    dir_d   = DIR_UP;
                end
            end
            MOVE_UP: begin
                if (tmr_zero) begin
                    nf      = cf + 1;
                    floor_d = FW'(nf);
                    stop    = req_in[nf] | req_up[nf] |
                              (req_down[nf] & !any_above(all_req, nf)) | (nf == FLOORS - 1);
                end
            end
            MOVE_DOWN: begin
                if (tmr_zero) begin
                    nf      = cf - 1;
                    floor_d = FW'(nf);
                    stop    = req_in[nf] | req_down[nf] |
                              (req_up[nf] & !any_below(all_req, nf)) | (nf == 0);
                end
            end
            DOOR: begin
                // Bits already being cleared this cycle are still visible from the latch; ignore them.
                srv = served_at(req_in, req_up, req_down, cf, dir_q) &
                      ~{clr_in_q[cf], clr_up_q[cf], clr_down_q[cf]};
                if (|srv || hold) begin
                    tmr_load = 1'b1; tmr_value = DOOR_LOAD;
                end else if (tmr_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == MOVE_UP || state_q == MOVE_DOWN) && tmr_zero) begin
            tmr_load = 1'b1;
            if (stop) begin
                state_d   = DOOR;
                tmr_value = DOOR_LOAD;
                srv       = served_at(req_in, req_up, req_down, nf, dir_q);
            end else begin
                tmr_value = TRAVEL_LOAD;
            end
        end

        clr_in_d   = srv[2] ? (ONE << nf) : '0;
        clr_up_d   = srv[1] ? (ONE << nf) : '0;
        clr_down_d = srv[0] ? (ONE << nf) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            floor_q      <= '0;
            dir_q        <= DIR_UP;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
            clr_in_q     <= '0;
            clr_up_q     <= '0;
            clr_down_q   <= '0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            dir_q        <= dir_d;
            motor_up_q   <= (state_d == MOVE_UP);
            motor_down_q <= (state_d == MOVE_DOWN);
            door_open_q  <= (state_d == DOOR);
            clr_in_q     <= clr_in_d;
            clr_up_q     <= clr_up_d;
            clr_down_q   <= clr_down_d;
        end
    end

    assign cur_floor  = floor_q;
    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign door_open  = door_open_q;
    assign dir_up     = dir_q;
    assign clr_in     = clr_in_q;
    assign clr_up     = clr_up_q;
    assign clr_down   = clr_down_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler with a behavioural button latch in front of it.
// Build with ELEVATOR_DOOR_HOLD_EN defined to also exercise the door hold input.
module tb_elevator_scheduler;

    localparam int FLOORS = 8;
    localparam int FT     = 16;
    localparam int DT     = 32;

    typedef struct packed {
        logic [2:0] fl;
        logic [7:0] ci;
        logic [7:0] cu;
        logic [7:0] cd;
    } stop_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] lat_in, lat_up, lat_dn;
    logic [7:0] set_in = '0, set_up = '0, set_dn = '0;
    logic [2:0] cur_floor;
    logic       motor_up, motor_down, door_open, dir_up;
    logic [7:0] clr_in, clr_up, clr_down;
`ifdef ELEVATOR_DOOR_HOLD_EN
    logic       door_hold = 1'b0;
`endif

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    stop_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Button latch: set has priority over clear.
    always @(posedge clk) begin
        if (!reset) begin
            lat_in <= '0; lat_up <= '0; lat_dn <= '0;
        end else begin
            lat_in <= (lat_in & ~clr_in)   | set_in;
            lat_up <= (lat_up & ~clr_up)   | set_up;
            lat_dn <= (lat_dn & ~clr_down) | set_dn;
        end
    end

    elevator_scheduler #(.FLOORS(FLOORS), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_in     (lat_in),
        .req_up     (lat_up),
        .req_down   (lat_dn),
`ifdef ELEVATOR_DOOR_HOLD_EN
        .door_hold  (door_hold),
`endif
        .cur_floor  (cur_floor),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .door_open  (door_open),
        .dir_up     (dir_up),
        .clr_in     (clr_in),
        .clr_up     (clr_up),
        .clr_down   (clr_down)
    );

    task automatic press(input logic [7:0] vi, input logic [7:0] vu, input logic [7:0] vd);
        @(negedge clk);
        set_in = vi; set_up = vu; set_dn = vd;
        @(negedge clk);
        set_in = '0; set_up = '0; set_dn = '0;
    endtask

    task automatic wait_clr(input int budget, output stop_t got);
        int n;
        n = 0;
        @(negedge clk);
        while (clr_in == 0 && clr_up == 0 && clr_down == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_clr: no clear pulse within %0d cycles", budget);
        end
        got = {cur_floor, clr_in, clr_up, clr_down};
    endtask

    task automatic wait_door_closed(input int budget);
        int n;
        n = 0;
        while (door_open && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_door_closed: door still open after %0d cycles", budget);
        end
    endtask

    task automatic wait_floor(input logic [2:0] target, input int budget);
        int n;
        n = 0;
        while (cur_floor != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_floor: floor %0d, required %0d within %0d cycles", cur_floor, target, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cur_floor, motor_up, motor_down, door_open, dir_up} !== {3'd0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_state: floor %0d mu %b md %b door %b dir %b, required 0 0 0 0 1",
                     cur_floor, motor_up, motor_down, door_open, dir_up);
        end
        checks++;
        if ({clr_in, clr_up, clr_down} !== 24'h0) begin
            errors++;
            $display("FAIL reset_clears: %h/%h/%h, required 0", clr_in, clr_up, clr_down);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (motor_up !== 1'b0 || door_open !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: mu %b door %b, required 0 0", motor_up, door_open);
        end
    endtask

    task automatic test_single_request();
        stop_t got, exp;
        int    t0;
        sb.push_back(stop_t'{3'd3, 8'h08, 8'h00, 8'h00});
        press(8'h08, 8'h00, 8'h00);
        checks++;
        if (motor_up !== 1'b0) begin
            errors++;
            $display("FAIL decision_early: motor_up %b, required 0", motor_up);
        end
        @(negedge clk);
        checks++;
        if (motor_up !== 1'b1 || cur_floor !== 3'd0) begin
            errors++;
            $display("FAIL decision_latency: motor_up %b floor %0d, required 1 0", motor_up, cur_floor);
        end
        t0 = cyc;
        wait_clr(200, got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL stop_floor3: floor %0d clr %h/%h/%h, required floor %0d clr %h/%h/%h",
                     got.fl, got.ci, got.cu, got.cd, exp.fl, exp.ci, exp.cu, exp.cd);
        end
        checks++;
        if (cyc - t0 !== 3 * FT) begin
            errors++;
            $display("FAIL travel_time: %0d cycles, required %0d", cyc - t0, 3 * FT);
        end
        @(negedge clk);
        checks++;
        if (clr_in !== 8'h00 || door_open !== 1'b1) begin
            errors++;
            $display("FAIL clr_one_cycle: clr_in %h door %b, required 00 1", clr_in, door_open);
        end
        wait_door_closed(100);
    endtask

    task automatic test_two_directions();
        stop_t got, exp;
        sb.push_back(stop_t'{3'd5, 8'h00, 8'h00, 8'h20});
        sb.push_back(stop_t'{3'd1, 8'h00, 8'h02, 8'h00});
        press(8'h00, 8'h02, 8'h20);
        for (int i = 0; i < 2; i++) begin
            wait_clr(400, got);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL two_dir_stop%0d: floor %0d clr %h/%h/%h, required floor %0d clr %h/%h/%h",
                         i, got.fl, got.ci, got.cu, got.cd, exp.fl, exp.ci, exp.cu, exp.cd);
            end
            checks++;
            if (dir_up !== (i == 0)) begin
                errors++;
                $display("FAIL two_dir_dir%0d: dir_up %b, required %b", i, dir_up, (i == 0));
            end
        end
        wait_door_closed(100);
    endtask

    task automatic test_pass_by();
        stop_t got, exp;
        sb.push_back(stop_t'{3'd6, 8'h40, 8'h00, 8'h00});
        press(8'h40, 8'h00, 8'h00);
        wait_floor(3'd3, 200);
        sb.push_back(stop_t'{3'd4, 8'h00, 8'h00, 8'h10});
        press(8'h00, 8'h00, 8'h10);
        for (int i = 0; i < 2; i++) begin
            wait_clr(400, got);
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pass_by_stop%0d: floor %0d clr %h/%h/%h, required floor %0d clr %h/%h/%h",
                         i, got.fl, got.ci, got.cu, got.cd, exp.fl, exp.ci, exp.cu, exp.cd);
            end
        end
        wait_door_closed(100);
    endtask

    task automatic test_door_reload();
        stop_t got, exp;
        int    k;
        sb.push_back(stop_t'{3'd2, 8'h04, 8'h00, 8'h00});
        press(8'h04, 8'h00, 8'h00);
        wait_clr(300, got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reload_first: floor %0d clr %h/%h/%h, required floor %0d clr %h/%h/%h",
                     got.fl, got.ci, got.cu, got.cd, exp.fl, exp.ci, exp.cu, exp.cd);
        end
        repeat (8) @(negedge clk);
        sb.push_back(stop_t'{3'd2, 8'h04, 8'h00, 8'h00});
        press(8'h04, 8'h00, 8'h00);
        wait_clr(10, got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reload_repress: floor %0d clr %h/%h/%h, required floor %0d clr %h/%h/%h",
                     got.fl, got.ci, got.cu, got.cd, exp.fl, exp.ci, exp.cu, exp.cd);
        end
        k = 0;
        while (door_open && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== DT) begin
            errors++;
            $display("FAIL reload_door_time: open %0d cycles after repress, required %0d", k, DT);
        end
    endtask

    task automatic test_top_floor();
        stop_t got, exp;
        sb.push_back(stop_t'{3'd7, 8'h00, 8'h00, 8'h80});
        press(8'h00, 8'h00, 8'h80);
        wait_clr(300, got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL top_stop: floor %0d clr %h/%h/%h, required floor %0d clr %h/%h/%h",
                     got.fl, got.ci, got.cu, got.cd, exp.fl, exp.ci, exp.cu, exp.cd);
        end
        wait_door_closed(100);
        repeat (5) @(negedge clk);
        checks++;
        if (cur_floor !== 3'd7 || motor_up !== 1'b0 || motor_down !== 1'b0) begin
            errors++;
            $display("FAIL top_idle: floor %0d mu %b md %b, required 7 0 0", cur_floor, motor_up, motor_down);
        end
    endtask

    task automatic test_reset_mid_travel();
        press(8'h01, 8'h00, 8'h00);
        wait_floor(3'd5, 300);
        repeat (3) @(negedge clk);
        checks++;
        if (motor_down !== 1'b1) begin
            errors++;
            $display("FAIL mid_travel_moving: motor_down %b, required 1", motor_down);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({cur_floor, motor_up, motor_down, door_open, dir_up} !== {3'd0, 4'b0001}) begin
            errors++;
            $display("FAIL mid_travel_reset: floor %0d mu %b md %b door %b dir %b, required 0 0 0 0 1",
                     cur_floor, motor_up, motor_down, door_open, dir_up);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({clr_in, clr_up, clr_down} !== 24'h0) begin
            errors++;
            $display("FAIL mid_travel_clears: %h/%h/%h, required 0", clr_in, clr_up, clr_down);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cur_floor !== 3'd0 || motor_down !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: floor %0d md %b, required 0 0", cur_floor, motor_down);
        end
    endtask

`ifdef ELEVATOR_DOOR_HOLD_EN
    task automatic test_door_hold();
        stop_t got, exp;
        int    k;
        logic  stayed;
        sb.push_back(stop_t'{3'd0, 8'h01, 8'h00, 8'h00});
        press(8'h01, 8'h00, 8'h00);
        wait_clr(10, got);
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL hold_stop: floor %0d clr %h/%h/%h, required floor %0d clr %h/%h/%h",
                     got.fl, got.ci, got.cu, got.cd, exp.fl, exp.ci, exp.cu, exp.cd);
        end
        door_hold = 1'b1;
        stayed = 1'b1;
        repeat (100) begin
            @(negedge clk);
            stayed = stayed & door_open;
        end
        door_hold = 1'b0;
        checks++;
        if (stayed !== 1'b1) begin
            errors++;
            $display("FAIL hold_open: door closed during hold, required open");
        end
        k = 0;
        while (door_open && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== DT) begin
            errors++;
            $display("FAIL hold_release: closed %0d cycles after release, required %0d", k, DT);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_request();
        test_two_directions();
        test_pass_by();
        test_door_reload();
        test_top_floor();
        test_reset_mid_travel();
`ifdef ELEVATOR_DOOR_HOLD_EN
        test_door_hold();
`endif
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
